// File: rtl/jnot_drv_pkg.sv
// Shared types and constants for the RSFQ inverter (jnot) pulse driver.
package jnot_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drv_state_t;

    typedef struct packed {
        logic valid;
        logic bit_val;
    } tag_t;

    localparam int SETUP_MIN_TICKS = 8;
    localparam int MAX_LOW_TICKS   = 4;

endpackage

// File: rtl/jnot_frame_timer.sv
// Frame tick counter with din / cell-clock pulse and dout sample-window decode.
module jnot_frame_timer #(
    parameter int FRAME_T  = 20,
    parameter int DIN_LEAD = 10,
    parameter int PULSE_W  = 2,
    parameter int WIN_LO   = 5,
    parameter int WIN_HI   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic frame_start,
    output logic frame_end,
    output logic din_pulse,
    output logic clk_pulse,
    output logic in_window
);

    localparam int TW        = $clog2(FRAME_T + 1);
    localparam int WIN_FIRST = DIN_LEAD + WIN_LO;
    // A window reaching the next frame start is clamped to this frame's last tick.
    localparam int WIN_LAST  = (DIN_LEAD + WIN_HI > FRAME_T - 1) ? FRAME_T - 1 : DIN_LEAD + WIN_HI;

    logic [TW-1:0] tick;
    int            tv;

    assign tv = {{(32-TW){1'b0}}, tick};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
        end else if (!run || tv == FRAME_T - 1) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign frame_start = run && (tv == 0);
    assign frame_end   = run && (tv == FRAME_T - 1);
    assign din_pulse   = run && (tv < PULSE_W);
    assign clk_pulse   = run && (tv >= DIN_LEAD) && (tv < DIN_LEAD + PULSE_W);
    assign in_window   = run && (tv >= WIN_FIRST) && (tv <= WIN_LAST);

endmodule

// File: rtl/jnot_pulse_driver.sv
// Stream-to-pulse driver for clocked RSFQ inverter cells with windowed dout decode.
// Optional dout timing checker enabled by defining JNOT_DRV_TIMING_CHECK_EN.
module jnot_pulse_driver
    import jnot_drv_pkg::*;
#(
    parameter int FRAME_T  = 20,
    parameter int DIN_LEAD = 10,
    parameter int PULSE_W  = 2,
    parameter int WIN_LO   = 5,
    parameter int WIN_HI   = 10,
    parameter int RES_LAT  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    output logic cell_din,
    output logic cell_clk,
    input  logic cell_dout,
    output logic res_valid,
    output logic res_bit,
    output logic err
);

    if (DIN_LEAD < SETUP_MIN_TICKS) begin : g_bad_setup
        $fatal(1, "DIN_LEAD=%0d below setup minimum %0d", DIN_LEAD, SETUP_MIN_TICKS);
    end
    if (DIN_LEAD >= FRAME_T || DIN_LEAD + PULSE_W > FRAME_T || PULSE_W < 1) begin : g_bad_pulse
        $fatal(1, "cell clock pulse does not fit in frame");
    end
    if (DIN_LEAD + WIN_HI > FRAME_T || WIN_LO > WIN_HI) begin : g_bad_window
        $fatal(1, "dout sample window does not fit in frame");
    end
    if (RES_LAT < 0 || RES_LAT > 3) begin : g_bad_lat
        $fatal(1, "RES_LAT=%0d out of range 0..3", RES_LAT);
    end

    drv_state_t state, state_nx;
    tag_t       pipe [RES_LAT+1];
    tag_t       retire;
    logic       run, xfer, low_seen, flag_now, pending_after;
    logic       frame_start, frame_end, din_pulse, clk_pulse, in_window;

    jnot_frame_timer #(
        .FRAME_T (FRAME_T),
        .DIN_LEAD(DIN_LEAD),
        .PULSE_W (PULSE_W),
        .WIN_LO  (WIN_LO),
        .WIN_HI  (WIN_HI)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .din_pulse  (din_pulse),
        .clk_pulse  (clk_pulse),
        .in_window  (in_window)
    );

    assign run      = (state != IDLE);
    assign xfer     = (state == RUN) && frame_start && bit_valid;
    assign flag_now = low_seen | (in_window & ~cell_dout);
    // pipe[0] is the current frame's tag; pipe[RES_LAT] owns this frame's window.
    assign retire   = pipe[RES_LAT];

    always_comb begin
        pending_after = 1'b0;
        for (int i = 0; i < RES_LAT; i++) begin
            pending_after = pending_after | pipe[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_seen <= 1'b0;
            for (int i = 0; i <= RES_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else if (frame_end) begin
            low_seen <= 1'b0;
            pipe[0]  <= '0;
            for (int i = 1; i <= RES_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end else begin
            if (in_window && !cell_dout) begin
                low_seen <= 1'b1;
            end
            if (frame_start) begin
                pipe[0] <= {xfer, xfer & bit_in};
            end
        end
    end

    always_comb begin
        state_nx  = state;
        bit_ready = 1'b0;
        cell_din  = 1'b0;
        cell_clk  = 1'b0;
        res_valid = 1'b0;
        res_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nx = RUN;
            end
            RUN: begin
                bit_ready = frame_start;
                // First din tick follows the live handshake; later ticks use the stored tag.
                cell_din  = frame_start ? (bit_valid & bit_in)
                                        : (din_pulse & pipe[0].valid & pipe[0].bit_val);
                if (frame_end && !enable) state_nx = DRAIN;
            end
            DRAIN: begin
                if (frame_end && !pending_after) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (run) begin
            cell_clk  = clk_pulse;
            res_valid = frame_end & retire.valid;
            res_bit   = frame_end & retire.valid & flag_now;
        end
    end

`ifdef JNOT_DRV_TIMING_CHECK_EN
    logic [2:0]  low_run;
    logic [15:0] viol_cnt;
    logic        viol, err_q;

    // low_run counts preceding consecutive low ticks, so the fifth low tick violates.
    assign viol = !cell_dout && (!in_window || {29'd0, low_run} >= MAX_LOW_TICKS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_run  <= '0;
            viol_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            low_run <= cell_dout ? 3'd0 : ((low_run == 3'd7) ? low_run : low_run + 3'd1);
            if (viol) begin
                err_q <= 1'b1;
                if (viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
